// File: rtl/gf_pkg.sv
// Shared types for the glitch-filter edge/event capture path.
package gf_pkg;

   localparam int NUM_CH      = 2;
   localparam int CNT_W       = 8;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_DROP_W  = 8;

   typedef enum logic {
      CH_IN1 = 1'b0,
      CH_IN2 = 1'b1
   } gf_chan_e;

   typedef struct packed {
      logic             chan;
      logic             level;
      logic [CNT_W-1:0] width;
   } gf_evt_t;

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gf_edge_event_capture_if.sv
// Event drain port: head of the event FIFO, valid/ready handshake.
interface gf_edge_event_capture_if;

   logic                     evt_valid;
   logic                     evt_ready;
   logic                     evt_chan;
   logic                     evt_level;
   logic [gf_pkg::CNT_W-1:0] evt_width;

   modport master (
      output evt_valid,
      output evt_chan,
      output evt_level,
      output evt_width,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_chan,
      input  evt_level,
      input  evt_width,
      output evt_ready
   );

endinterface

// File: rtl/gf_evt_fifo.sv
// 2-write/1-read first-word-fall-through event FIFO; head valid one cycle after write.
// Reader pops on rd_en while non-empty; writer must keep writes within the reported free count.
module gf_evt_fifo
   import gf_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               wr_en,
   input  gf_evt_t                  wr_data [2],
   input  logic                     rd_en,
   output logic                     rd_vld,
   output gf_evt_t                  rd_data,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int PW = $clog2(DEPTH);

   gf_evt_t         mem_q [DEPTH];
   gf_evt_t         mem_d [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [PW:0]     count_q, count_d;
   logic [PW-1:0]   wptr_nx;
   logic [PW:0]     n_wr;
   logic            pop;

   always_comb begin
      mem_d   = mem_q;
      wptr_nx = wptr_q + 1'b1;
      pop     = rd_en && (count_q != '0);
      n_wr    = {{PW{1'b0}}, wr_en[0]} + {{PW{1'b0}}, wr_en[1]};

      // ch1 takes the slot after ch0 when both write, otherwise the current slot.
      if (wr_en[0]) begin
         mem_d[wptr_q] = wr_data[0];
      end
      if (wr_en[1]) begin
         if (wr_en[0]) begin
            mem_d[wptr_nx] = wr_data[1];
         end else begin
            mem_d[wptr_q] = wr_data[1];
         end
      end

      wptr_d  = wptr_q + n_wr[PW-1:0];
      rptr_d  = rptr_q + PW'(pop);
      count_d = count_q + n_wr - {{PW{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign rd_vld  = (count_q != '0);
   assign rd_data = mem_q[rptr_q];
   assign free    = (PW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/gf_edge_event_capture.sv
// Turns level changes on two filtered inputs into {chan, level, width} events, queued for a consumer.
// Event visible one cycle after the edge; when the queue lacks room ch0 wins and the rest are counted as drops.
module gf_edge_event_capture
   import gf_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DROP_W = DEF_DROP_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       filt_in1,
   input  logic                       filt_in2,
   gf_edge_event_capture_if.master    evt,
   output logic                       ovf,
   output logic [DROP_W-1:0]          drop_cnt,
   input  logic                       clr_ovf
);

   localparam int FW = $clog2(DEPTH) + 1;

   logic [NUM_CH-1:0]  in_vec;
   logic [NUM_CH-1:0]  prev_q, prev_d;
   logic [NUM_CH-1:0]  edge_det;
   logic [CNT_W-1:0]   cnt_q [NUM_CH];
   logic [CNT_W-1:0]   cnt_d [NUM_CH];
   gf_evt_t            evt_req [NUM_CH];

   logic [1:0]         wr_en;
   logic [1:0]         n_drop;
   logic [FW-1:0]      free;
   logic               head_vld;
   gf_evt_t            head;

   logic               ovf_q, ovf_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic [DROP_W-1:0]  drop_base;
   logic [DROP_W:0]    drop_sum;

   assign in_vec = {filt_in2, filt_in1};
   assign prev_d = in_vec;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam gf_chan_e CH = (c == 0) ? CH_IN1 : CH_IN2;

      assign edge_det[c] = (in_vec[c] != prev_q[c]);
      assign cnt_d[c]    = edge_det[c] ? CNT_W'(1) : sat_inc(cnt_q[c]);
      assign evt_req[c]  = '{chan: CH, level: prev_q[c], width: cnt_q[c]};
   end

   // Space is judged on the registered occupancy; a same-cycle pop does not help.
   always_comb begin
      wr_en  = '0;
      n_drop = '0;
      if (free >= FW'(2)) begin
         wr_en = edge_det;
      end else if (free == FW'(1)) begin
         if (edge_det[0]) begin
            wr_en[0] = 1'b1;
            n_drop   = {1'b0, edge_det[1]};
         end else begin
            wr_en[1] = edge_det[1];
         end
      end else begin
         n_drop = {1'b0, edge_det[0]} + {1'b0, edge_det[1]};
      end
   end

   always_comb begin
      drop_base = clr_ovf ? '0 : drop_q;
      drop_sum  = {1'b0, drop_base} + (DROP_W+1)'(n_drop);
      drop_d    = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      ovf_d     = (n_drop != 2'd0) || (ovf_q && !clr_ovf);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         cnt_q  <= '{default: '0};
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
      end
   end

   gf_evt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (evt_req),
      .rd_en   (evt.evt_ready),
      .rd_vld  (head_vld),
      .rd_data (head),
      .free    (free)
   );

   assign evt.evt_valid = head_vld;
   assign evt.evt_chan  = head.chan;
   assign evt.evt_level = head.level;
   assign evt.evt_width = head.width;
   assign ovf           = ovf_q;
   assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_gf_edge_event_capture.sv
// Randomised plus directed bench for gf_edge_event_capture, scoreboarded against an event-timestamp model.
module tb_gf_edge_event_capture;
   import gf_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int MAXW   = (1 << CNT_W) - 1;
   localparam int MAXD   = (1 << DROP_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              filt_in1;
   logic              filt_in2;
   logic              clr_ovf;
   logic              ovf;
   logic [DROP_W-1:0] drop_cnt;

   gf_edge_event_capture_if evt_if ();

   gf_edge_event_capture #(
      .DEPTH  (DEPTH),
      .DROP_W (DROP_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .filt_in1 (filt_in1),
      .filt_in2 (filt_in2),
      .evt      (evt_if),
      .ovf      (ovf),
      .drop_cnt (drop_cnt),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   int      n_tests = 0;
   int      n_fail  = 0;
   gf_evt_t exp_q [$];
   gf_evt_t mon_e;

   // Model: each channel remembers the cycle its current level began; width is elapsed cycles.
   int      t = 0;
   int      start_t [2];
   logic    mlevel [2];
   int      mcnt  = 0;
   int      mdrop = 0;
   bit      movf  = 1'b0;
   logic    cur1 = 1'b0;
   logic    cur2 = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, t);
      end
   endtask

   task automatic step(input logic i1, input logic i2, input logic rdy,
                       input logic clr, input logic r);
      logic    inv [2];
      int      free;
      int      acc;
      int      pops;
      int      w;
      gf_evt_t e;
      rst = r;
      filt_in1 = i1;
      filt_in2 = i2;
      clr_ovf = clr;
      evt_if.evt_ready = rdy;
      cur1 = i1;
      cur2 = i2;
      if (r) begin
         for (int c = 0; c < 2; c++) begin
            mlevel[c]  = 1'b0;
            start_t[c] = t + 1;
         end
         mcnt  = 0;
         mdrop = 0;
         movf  = 1'b0;
         exp_q.delete();
      end else begin
         inv[0] = i1;
         inv[1] = i2;
         acc    = 0;
         pops   = (mcnt > 0 && rdy) ? 1 : 0;
         free   = DEPTH - mcnt;
         if (clr) begin
            mdrop = 0;
            movf  = 1'b0;
         end
         for (int c = 0; c < 2; c++) begin
            if (inv[c] !== mlevel[c]) begin
               w = t - start_t[c];
               if (w > MAXW) w = MAXW;
               e.chan  = (c == 1);
               e.level = mlevel[c];
               e.width = CNT_W'(w);
               if (free > 0) begin
                  exp_q.push_back(e);
                  free--;
                  acc++;
               end else begin
                  if (mdrop < MAXD) mdrop++;
                  movf = 1'b1;
               end
               start_t[c] = t;
               mlevel[c]  = inv[c];
            end
         end
         mcnt = mcnt + acc - pops;
      end
      @(posedge clk);
      #1;
      t++;
      chk("evt_valid", 32'(evt_if.evt_valid), 32'(mcnt > 0));
      chk("ovf", 32'(ovf), 32'(movf));
      chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
      if (r) begin
         chk("rst_head", {evt_if.evt_chan, evt_if.evt_level, evt_if.evt_width}, 32'd0);
      end
   endtask

   task automatic hold(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(cur1, cur2, rdy, 1'b0, 1'b0);
   endtask

   // Monitor: each accepted head is matched against the oldest expected event.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got chan %0d width %0d expected no event",
                        evt_if.evt_chan, evt_if.evt_width);
            end else begin
               mon_e = exp_q.pop_front();
               chk("evt_chan", 32'(evt_if.evt_chan), 32'(mon_e.chan));
               chk("evt_level", 32'(evt_if.evt_level), 32'(mon_e.level));
               chk("evt_width", 32'(evt_if.evt_width), 32'(mon_e.width));
            end
         end
      end
   end

   initial begin
      int  rdy_pct;
      int  guard;
      rst = 1'b1;
      filt_in1 = 1'b0;
      filt_in2 = 1'b0;
      clr_ovf = 1'b0;
      evt_if.evt_ready = 1'b0;

      // Low for 5 cycles after reset, then high: width 5.
      step(0, 0, 1, 0, 1);
      hold(5, 1'b1);
      step(1, 0, 1, 0, 0);
      chk("t1_width", 32'(evt_if.evt_width), 32'd5);
      chk("t1_chan_level", {evt_if.evt_chan, evt_if.evt_level}, 32'd0);
      hold(3, 1'b1);

      // Long hold on ch1 saturates the width.
      step(1, 1, 1, 0, 0);
      hold(300, 1'b1);
      step(1, 0, 1, 0, 0);
      chk("t2_head", {evt_if.evt_chan, evt_if.evt_level, evt_if.evt_width}, {22'd0, 1'b1, 1'b1, 8'd255});
      hold(3, 1'b1);

      // Simultaneous edges: ch0 first.
      step(0, 1, 1, 0, 0);
      chk("t3_head_chan", 32'(evt_if.evt_chan), 32'd0);
      hold(4, 1'b1);

      // Six edges with no consumer: four queued, two dropped.
      for (int i = 0; i < 6; i++) begin
         step(~cur1, cur2, 0, 0, 0);
         hold(1, 1'b0);
      end
      chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
      chk("t4_ovf", 32'(ovf), 32'd1);
      step(cur1, cur2, 0, 1, 0);
      chk("t4_clr", {ovf, drop_cnt}, 32'd0);
      hold(6, 1'b1);

      // Full queue: pop and new edge together, the edge is still dropped.
      for (int i = 0; i < 4; i++) step(~cur1, cur2, 0, 0, 0);
      step(cur1, ~cur2, 1, 0, 0);
      chk("t5_drop_cnt", 32'(drop_cnt), 32'd1);
      hold(6, 1'b1);

      // Reset with three entries queued flushes them.
      for (int i = 0; i < 3; i++) step(~cur1, cur2, 0, 0, 0);
      step(cur1, cur2, 0, 0, 1);
      hold(7, 1'b0);
      step(~cur1, ~cur2, 1, 0, 0);
      hold(4, 1'b1);

      // Random traffic with varying consumer pressure.
      for (int blk = 0; blk < 15; blk++) begin
         rdy_pct = $urandom_range(0, 100);
         for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 7) == 0) ? ~cur1 : cur1,
                 ($urandom_range(0, 7) == 0) ? ~cur2 : cur2,
                 ($urandom_range(1, 100) <= rdy_pct),
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 499) == 0));
         end
      end

      // Drain, bounded.
      guard = 0;
      while (mcnt > 0 && guard < 50) begin
         hold(1, 1'b1);
         guard++;
      end
      hold(2, 1'b1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
